trap_controller: RTL and testbench
==================================

TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/CSR width.
REQ-002 SHALL have parameter HOLD_CYCLES, default 2, range 1-7, meaning post-redirect pipeline hold length.
REQ-003 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- exmem_valid  in  1  valid instruction in MEM.
- exmem_pc  in  XLEN  PC of that instruction.
- exmem_is_mret / exmem_is_sret  in  1 each  xRET in MEM.
- mem_stall  in  1  MEM stage stalled.
- exception  in  1  synchronous exception on the MEM instruction.
- exception_cause  in  5  exception code.
- exception_tval  in  XLEN  trap value.
- irq_pending  in  12  mip & mie.
- current_priv  in  2  current privilege mode.
- mstatus_mie / mstatus_sie / mstatus_tsr  in  1 each  status bits.
- medeleg / mideleg  in  XLEN  delegation masks.
- mtvec / stvec / mepc / sepc  in  XLEN  CSR values.
- trap_flush  out  1  trap entry pulse.
- trap_target_priv  out  2  target mode of the trap.
- mret_flush / sret_flush  out  1 each  xRET commit pulses.
- redirect_valid  out  1  PC redirect pulse.
- redirect_pc  out  XLEN  redirect target.
- csr_trap_we  out  1  write strobe for cause/epc/tval/status.
- csr_trap_cause  out  XLEN  {interrupt bit, zero fill, code}.
- csr_trap_epc / csr_trap_tval  out  XLEN  values to write.
- pipe_hold  out  1  freeze IF through MEM.

Function
REQ-004 SHALL use a state machine with states IDLE, COMMIT and HOLD.
REQ-005 In IDLE with exmem_valid=1 and mem_stall=0, SHALL select one event. Priority: exception, then illegal SRET, then interrupt, then MRET, then SRET.
REQ-006 Illegal SRET SHALL mean exmem_is_sret with current_priv=U, or with current_priv=S and mstatus_tsr=1. It SHALL be treated as exception cause 2 with tval 0.
REQ-007 Interrupt code SHALL be the highest pending in order 11, 3, 7, 9, 1, 5.
- Non-delegated interrupts are taken when current_priv<M, or when current_priv=M and mstatus_mie=1.
- Delegated interrupts are taken when current_priv=U, or when current_priv=S and mstatus_sie=1.
- Delegated interrupts are never taken when current_priv=M.
REQ-008 Target SHALL be S (2'b01) when current_priv!=M and the relevant bit is set: medeleg[cause] for exceptions, mideleg[code] for interrupts. Otherwise target SHALL be M (2'b11).
REQ-009 On selection, SHALL register the event kind, cause, epc (exmem_pc), tval (exception_tval for exceptions, 0 for interrupts) and target, then go to COMMIT.
REQ-010 In COMMIT (exactly 1 cycle), for a trap SHALL assert the following, then go to HOLD:
- trap_flush, redirect_valid, csr_trap_we.
- trap_target_priv and the csr_trap_* outputs.
REQ-011 Trap redirect_pc SHALL be {tvec[XLEN-1:2],2'b00}, using stvec when the target is S and mtvec otherwise. If the trap is an interrupt and tvec[1:0]=01, SHALL add 4*code. Arithmetic is modulo 2^XLEN.
REQ-012 In COMMIT for MRET, SHALL assert mret_flush and redirect_valid with redirect_pc=mepc. For SRET, SHALL assert sret_flush and redirect_valid with redirect_pc=sepc. csr_trap_we SHALL be 0 in both cases.
REQ-013 pipe_hold SHALL be 1 in COMMIT and HOLD, and 0 in IDLE.
REQ-014 HOLD SHALL last HOLD_CYCLES cycles, then return to IDLE. All inputs are ignored outside IDLE.
REQ-015 All pulse outputs SHALL be high for exactly one cycle per event. Latency from selection edge to pulse is 1 cycle.
REQ-016 With exmem_valid=0 or mem_stall=1, IDLE SHALL take no event. A pending interrupt waits for the next valid unstalled MEM instruction.
REQ-017 If exception and xRET occur together, SHALL take only the exception. If exception and an interrupt occur together, SHALL take only the exception.

Reset
REQ-018 While reset=1, SHALL force state IDLE.
REQ-019 While reset=1, all pulse outputs and pipe_hold SHALL be 0, trap_target_priv SHALL be 2'b11, and all XLEN outputs SHALL be 0.
REQ-020 Reset asserted in COMMIT or HOLD SHALL abort the event with no pulse emitted afterwards.

Verification
REQ-021 The bench SHALL cover at least these scenarios:
- Exception: priv=U, cause 8, medeleg[8]=1, stvec=0x8000_0101, pc=0x100 -> next cycle trap_flush=1, target=01, redirect_pc=0x8000_0100, epc=0x100, cause=0x8; pipe_hold high 3 cycles.
- Interrupt: priv=M, mie=1, irq_pending=0x880, mtvec=0x2001 -> code 11 chosen; redirect_pc=0x202C, cause=0x8000_000B, tval=0.
- MRET: MRET with mepc=0x4000, plus exception cause 2 the same cycle -> only trap_flush; then a lone MRET -> mret_flush=1, redirect_pc=0x4000, csr_trap_we=0.
- SRET: SRET with priv=S, tsr=1 -> trap cause 2 to M; with tsr=0 and sepc=0x3000 -> sret_flush=1, redirect_pc=0x3000.
- Gating: priv=M, mideleg[5]=1, irq_pending=0x020 -> no event. Separately, mem_stall=1 for 3 cycles with an exception present -> capture on the first unstalled cycle.
- Reset: reset asserted in HOLD -> all outputs 0, target=11; no pulses until a new event.

Source files
------------

// File: rtl/trap_controller_if.sv
// MEM-stage trap/xRET interface: retiring-instruction info and CSR state in,
// flush/redirect/CSR-write commands out.
interface trap_controller_if #(
    parameter int unsigned XLEN = 32
);
    logic            exmem_valid;
    logic [XLEN-1:0] exmem_pc;
    logic            exmem_is_mret;
    logic            exmem_is_sret;
    logic            mem_stall;
    logic            exception;
    logic [4:0]      exception_cause;
    logic [XLEN-1:0] exception_tval;
    logic [11:0]     irq_pending;
    logic [1:0]      current_priv;
    logic            mstatus_mie;
    logic            mstatus_sie;
    logic            mstatus_tsr;
    logic [XLEN-1:0] medeleg;
    logic [XLEN-1:0] mideleg;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] stvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] sepc;

    logic            trap_flush;
    logic [1:0]      trap_target_priv;
    logic            mret_flush;
    logic            sret_flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            csr_trap_we;
    logic [XLEN-1:0] csr_trap_cause;
    logic [XLEN-1:0] csr_trap_epc;
    logic [XLEN-1:0] csr_trap_tval;
    logic            pipe_hold;

    modport master (
        output exmem_valid, exmem_pc, exmem_is_mret, exmem_is_sret, mem_stall,
               exception, exception_cause, exception_tval, irq_pending,
               current_priv, mstatus_mie, mstatus_sie, mstatus_tsr,
               medeleg, mideleg, mtvec, stvec, mepc, sepc,
        input  trap_flush, trap_target_priv, mret_flush, sret_flush,
               redirect_valid, redirect_pc, csr_trap_we, csr_trap_cause,
               csr_trap_epc, csr_trap_tval, pipe_hold
    );

    modport slave (
        input  exmem_valid, exmem_pc, exmem_is_mret, exmem_is_sret, mem_stall,
               exception, exception_cause, exception_tval, irq_pending,
               current_priv, mstatus_mie, mstatus_sie, mstatus_tsr,
               medeleg, mideleg, mtvec, stvec, mepc, sepc,
        output trap_flush, trap_target_priv, mret_flush, sret_flush,
               redirect_valid, redirect_pc, csr_trap_we, csr_trap_cause,
               csr_trap_epc, csr_trap_tval, pipe_hold
    );
endinterface

// File: rtl/trap_controller.sv
// Trap/xRET arbiter for the MEM stage: picks one event per retiring instruction,
// issues a one-cycle commit (flush, redirect, CSR write) and then holds the pipe.
module trap_controller #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input logic             clk,
    input logic             reset,
    trap_controller_if.slave bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [1:0]  PRIV_U = 2'b00;
    localparam logic [1:0]  PRIV_S = 2'b01;
    localparam logic [1:0]  PRIV_M = 2'b11;
    localparam logic [3:0]  IRQ_ORDER [6] = '{4'd11, 4'd3, 4'd7, 4'd9, 4'd1, 4'd5};

    typedef enum logic [1:0] {IDLE, COMMIT, HOLD} state_t;
    typedef enum logic [1:0] {EV_TRAP, EV_MRET, EV_SRET} ev_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  hold_cnt, hold_cnt_next;

    logic              take;
    logic              illegal_sret;
    logic [11:0]       irq_enabled;
    logic              irq_take;
    logic [4:0]        irq_code;
    logic              sel_valid;
    ev_t               sel_kind;
    logic              sel_int;
    logic [4:0]        sel_code;
    logic [XLEN-1:0]   sel_tval;
    logic              sel_deleg;
    logic [1:0]        sel_target;
    logic [XLEN-1:0]   tvec;
    logic [XLEN-1:0]   trap_pc;
    logic              unused_mideleg;

    logic              trap_flush_d, mret_flush_d, sret_flush_d;
    logic              redirect_valid_d, csr_trap_we_d, pipe_hold_d;
    logic [1:0]        trap_target_priv_d;
    logic [XLEN-1:0]   redirect_pc_d, csr_trap_cause_d, csr_trap_epc_d, csr_trap_tval_d;

    assign unused_mideleg = ^bus.mideleg[XLEN-1:12];

    assign take         = bus.exmem_valid && !bus.mem_stall;
    assign illegal_sret = bus.exmem_is_sret &&
                          (bus.current_priv == PRIV_U ||
                           (bus.current_priv == PRIV_S && bus.mstatus_tsr));

    // Per-line interrupt enable, then fixed-priority pick among enabled lines
    always_comb begin
        irq_enabled = '0;
        irq_take    = 1'b0;
        irq_code    = '0;
        for (int b = 0; b < 12; b++) begin
            if (bus.mideleg[b])
                irq_enabled[b] = bus.irq_pending[b] &&
                                 (bus.current_priv == PRIV_U ||
                                  (bus.current_priv == PRIV_S && bus.mstatus_sie));
            else
                irq_enabled[b] = bus.irq_pending[b] &&
                                 (bus.current_priv != PRIV_M || bus.mstatus_mie);
        end
        for (int i = 5; i >= 0; i--) begin
            if (irq_enabled[IRQ_ORDER[i]]) begin
                irq_take = 1'b1;
                irq_code = 5'(IRQ_ORDER[i]);
            end
        end
    end

    // Event selection: exception > illegal SRET > interrupt > MRET > SRET
    always_comb begin
        sel_valid = 1'b0;
        sel_kind  = EV_TRAP;
        sel_int   = 1'b0;
        sel_code  = '0;
        sel_tval  = '0;
        sel_deleg = 1'b0;
        if (take) begin
            if (bus.exception) begin
                sel_valid = 1'b1;
                sel_code  = bus.exception_cause;
                sel_tval  = bus.exception_tval;
                sel_deleg = bus.medeleg[bus.exception_cause];
            end else if (illegal_sret) begin
                sel_valid = 1'b1;
                sel_code  = 5'd2;
                sel_deleg = bus.medeleg[2];
            end else if (irq_take) begin
                sel_valid = 1'b1;
                sel_int   = 1'b1;
                sel_code  = irq_code;
                sel_deleg = bus.mideleg[irq_code];
            end else if (bus.exmem_is_mret) begin
                sel_valid = 1'b1;
                sel_kind  = EV_MRET;
            end else if (bus.exmem_is_sret) begin
                sel_valid = 1'b1;
                sel_kind  = EV_SRET;
            end
        end
    end

    assign sel_target = (bus.current_priv != PRIV_M && sel_deleg) ? PRIV_S : PRIV_M;
    assign tvec       = (sel_target == PRIV_S) ? bus.stvec : bus.mtvec;
    assign trap_pc    = {tvec[XLEN-1:2], 2'b00} +
                        ((sel_int && tvec[1:0] == 2'b01) ? XLEN'({sel_code, 2'b00}) : '0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_cnt_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next    = state;
        hold_cnt_next = hold_cnt;
        unique case (state)
            IDLE:   if (sel_valid) state_next = COMMIT;
            COMMIT: begin
                state_next    = HOLD;
                hold_cnt_next = CNT_W'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (hold_cnt == '0) state_next = IDLE;
                else                hold_cnt_next = hold_cnt - CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered commit outputs
    always_comb begin
        trap_flush_d       = 1'b0;
        mret_flush_d       = 1'b0;
        sret_flush_d       = 1'b0;
        redirect_valid_d   = 1'b0;
        csr_trap_we_d      = 1'b0;
        trap_target_priv_d = PRIV_M;
        redirect_pc_d      = '0;
        csr_trap_cause_d   = '0;
        csr_trap_epc_d     = '0;
        csr_trap_tval_d    = '0;
        pipe_hold_d        = (state_next != IDLE);
        if (state == IDLE && sel_valid) begin
            redirect_valid_d = 1'b1;
            unique case (sel_kind)
                EV_MRET: begin
                    mret_flush_d  = 1'b1;
                    redirect_pc_d = bus.mepc;
                end
                EV_SRET: begin
                    sret_flush_d  = 1'b1;
                    redirect_pc_d = bus.sepc;
                end
                default: begin
                    trap_flush_d       = 1'b1;
                    csr_trap_we_d      = 1'b1;
                    trap_target_priv_d = sel_target;
                    redirect_pc_d      = trap_pc;
                    csr_trap_cause_d   = {sel_int, {(XLEN-6){1'b0}}, sel_code};
                    csr_trap_epc_d     = bus.exmem_pc;
                    csr_trap_tval_d    = sel_tval;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.trap_flush       <= 1'b0;
            bus.mret_flush       <= 1'b0;
            bus.sret_flush       <= 1'b0;
            bus.redirect_valid   <= 1'b0;
            bus.csr_trap_we      <= 1'b0;
            bus.pipe_hold        <= 1'b0;
            bus.trap_target_priv <= PRIV_M;
            bus.redirect_pc      <= '0;
            bus.csr_trap_cause   <= '0;
            bus.csr_trap_epc     <= '0;
            bus.csr_trap_tval    <= '0;
        end else begin
            bus.trap_flush       <= trap_flush_d;
            bus.mret_flush       <= mret_flush_d;
            bus.sret_flush       <= sret_flush_d;
            bus.redirect_valid   <= redirect_valid_d;
            bus.csr_trap_we      <= csr_trap_we_d;
            bus.pipe_hold        <= pipe_hold_d;
            bus.trap_target_priv <= trap_target_priv_d;
            bus.redirect_pc      <= redirect_pc_d;
            bus.csr_trap_cause   <= csr_trap_cause_d;
            bus.csr_trap_epc     <= csr_trap_epc_d;
            bus.csr_trap_tval    <= csr_trap_tval_d;
        end
    end
endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: exception, interrupt, xRET, gating and
// reset-abort vectors with hand-computed expectations.
module tb_trap_controller;
    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    trap_controller_if #(.XLEN(XLEN)) bus ();

    trap_controller #(.XLEN(XLEN), .HOLD_CYCLES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.exmem_valid     = 1'b0;
        bus.exmem_pc        = '0;
        bus.exmem_is_mret   = 1'b0;
        bus.exmem_is_sret   = 1'b0;
        bus.mem_stall       = 1'b0;
        bus.exception       = 1'b0;
        bus.exception_cause = '0;
        bus.exception_tval  = '0;
        bus.irq_pending     = '0;
        bus.current_priv    = 2'b11;
        bus.mstatus_mie     = 1'b0;
        bus.mstatus_sie     = 1'b0;
        bus.mstatus_tsr     = 1'b0;
        bus.medeleg         = '0;
        bus.mideleg         = '0;
        bus.mtvec           = '0;
        bus.stvec           = '0;
        bus.mepc            = '0;
        bus.sepc            = '0;
    endtask

    // {trap_flush, mret_flush, sret_flush, redirect_valid, csr_trap_we, pipe_hold}
    function automatic logic [5:0] ctl();
        return {bus.trap_flush, bus.mret_flush, bus.sret_flush,
                bus.redirect_valid, bus.csr_trap_we, bus.pipe_hold};
    endfunction

    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.pipe_hold && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check({tag, "_back_idle"}, ctl(), 6'b000000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctl",    ctl(), 6'b000000);
        check("rst_target", bus.trap_target_priv, 2'b11);
        check("rst_pc",     bus.redirect_pc, 0);
        check("rst_cause",  bus.csr_trap_cause, 0);
        check("rst_epc",    bus.csr_trap_epc, 0);
        check("rst_tval",   bus.csr_trap_tval, 0);
        reset = 1'b0;
        @(negedge clk);

        // Delegated exception from U; inputs stay asserted during hold and must be ignored
        bus.current_priv = 2'b00; bus.exception = 1'b1; bus.exception_cause = 5'd8;
        bus.medeleg = 32'h100; bus.stvec = 32'h8000_0101; bus.exmem_pc = 32'h100;
        bus.exception_tval = 32'h55; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("exc_ctl",    ctl(), 6'b100111);
        check("exc_target", bus.trap_target_priv, 2'b01);
        check("exc_pc",     bus.redirect_pc, 32'h8000_0100);
        check("exc_epc",    bus.csr_trap_epc, 32'h100);
        check("exc_cause",  bus.csr_trap_cause, 32'h8);
        check("exc_tval",   bus.csr_trap_tval, 32'h55);
        @(negedge clk);
        check("exc_hold1",  ctl(), 6'b000001);
        @(negedge clk);
        check("exc_hold2",  ctl(), 6'b000001);
        idle_inputs();
        @(negedge clk);
        check("exc_hold_end", ctl(), 6'b000000);

        // M-mode vectored interrupt, code 11 beats 7
        bus.current_priv = 2'b11; bus.mstatus_mie = 1'b1; bus.irq_pending = 12'h880;
        bus.mtvec = 32'h2001; bus.exmem_pc = 32'h200; bus.exception_tval = 32'h77;
        bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("irq_ctl",    ctl(), 6'b100111);
        check("irq_target", bus.trap_target_priv, 2'b11);
        check("irq_pc",     bus.redirect_pc, 32'h202C);
        check("irq_cause",  bus.csr_trap_cause, 32'h8000_000B);
        check("irq_tval",   bus.csr_trap_tval, 0);
        check("irq_epc",    bus.csr_trap_epc, 32'h200);
        idle_inputs();
        wait_idle("irq");

        // Delegated interrupt from U, vectored via stvec, code 5
        bus.current_priv = 2'b00; bus.mideleg = 32'h20; bus.irq_pending = 12'h020;
        bus.stvec = 32'h8001; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("sirq_target", bus.trap_target_priv, 2'b01);
        check("sirq_pc",     bus.redirect_pc, 32'h8014);
        check("sirq_cause",  bus.csr_trap_cause, 32'h8000_0005);
        idle_inputs();
        wait_idle("sirq");

        // MRET together with an exception: exception wins
        bus.exmem_is_mret = 1'b1; bus.mepc = 32'h4000; bus.exception = 1'b1;
        bus.exception_cause = 5'd2; bus.mtvec = 32'h1000; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("mx_ctl",   ctl(), 6'b100111);
        check("mx_pc",    bus.redirect_pc, 32'h1000);
        check("mx_cause", bus.csr_trap_cause, 32'h2);
        idle_inputs();
        wait_idle("mx");

        bus.exmem_is_mret = 1'b1; bus.mepc = 32'h4000; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("mret_ctl", ctl(), 6'b010101);
        check("mret_pc",  bus.redirect_pc, 32'h4000);
        idle_inputs();
        @(negedge clk);
        check("mret_pulse_end", ctl(), 6'b000001);
        wait_idle("mret");

        // SRET in S with TSR set traps as illegal instruction to M
        bus.current_priv = 2'b01; bus.exmem_is_sret = 1'b1; bus.mstatus_tsr = 1'b1;
        bus.exception_tval = 32'h99; bus.mtvec = 32'h1000; bus.sepc = 32'h3000;
        bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("isret_ctl",    ctl(), 6'b100111);
        check("isret_target", bus.trap_target_priv, 2'b11);
        check("isret_cause",  bus.csr_trap_cause, 32'h2);
        check("isret_tval",   bus.csr_trap_tval, 0);
        check("isret_pc",     bus.redirect_pc, 32'h1000);
        idle_inputs();
        wait_idle("isret");

        bus.current_priv = 2'b01; bus.exmem_is_sret = 1'b1; bus.sepc = 32'h3000;
        bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("sret_ctl", ctl(), 6'b001101);
        check("sret_pc",  bus.redirect_pc, 32'h3000);
        idle_inputs();
        wait_idle("sret");

        // Delegated interrupt never taken in M
        bus.mstatus_mie = 1'b1; bus.mideleg = 32'h20; bus.irq_pending = 12'h020;
        bus.exmem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gate_m", ctl(), 6'b000000);
        end
        idle_inputs();

        // Stalled MEM: exception captured only once the stall drops
        bus.exception = 1'b1; bus.exception_cause = 5'd5; bus.mtvec = 32'h1001;
        bus.exmem_pc = 32'h500; bus.mem_stall = 1'b1; bus.exmem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall", ctl(), 6'b000000);
        end
        bus.mem_stall = 1'b0;
        @(negedge clk);
        check("unstall_ctl",   ctl(), 6'b100111);
        check("unstall_cause", bus.csr_trap_cause, 32'h5);
        check("unstall_pc",    bus.redirect_pc, 32'h1000);
        check("unstall_epc",   bus.csr_trap_epc, 32'h500);
        idle_inputs();
        wait_idle("unstall");

        // Reset asserted during HOLD aborts the event
        bus.exception = 1'b1; bus.exception_cause = 5'd8; bus.exmem_pc = 32'h600;
        bus.mtvec = 32'h1000; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("rh_commit", ctl(), 6'b100111);
        idle_inputs();
        @(negedge clk);
        check("rh_hold", ctl(), 6'b000001);
        reset = 1'b1;
        #1;
        check("rh_ctl",    ctl(), 6'b000000);
        check("rh_target", bus.trap_target_priv, 2'b11);
        check("rh_pc",     bus.redirect_pc, 0);
        check("rh_cause",  bus.csr_trap_cause, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rh_quiet", ctl(), 6'b000000);
        end
        bus.exmem_is_mret = 1'b1; bus.mepc = 32'h4000; bus.exmem_valid = 1'b1;
        @(negedge clk);
        check("rh_new_ctl", ctl(), 6'b010101);
        check("rh_new_pc",  bus.redirect_pc, 32'h4000);
        idle_inputs();
        wait_idle("rh_new");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
